// File: rtl/cnn_pkg.sv
// Shared CNN back-end definitions: packer FSM states and default frame geometry
// common to score_packer and argmax.
package cnn_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int unsigned CNN_N     = 4;
    localparam int unsigned CNN_WIDTH = 16;

    // Counter width that stays legal (>= 1 bit) for any class count.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/score_packer.sv
// Collects N serial WIDTH-bit scores into one packed vector for argmax, holding it
// until consumed; short frames are zero-padded, long frames truncated, both flagged.
module score_packer
    import cnn_pkg::*;
#(
    parameter int unsigned N     = CNN_N,
    parameter int unsigned WIDTH = CNN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N*WIDTH-1:0]   m_vec,
    output logic                 frame_err
);

    localparam int unsigned    CW        = cnt_width(N);
    localparam logic [CW-1:0]  LAST_SLOT = CW'(N - 1);

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_next;
    logic [N*WIDTH-1:0]   r_vec;
    logic                 r_s_ready;
    logic                 r_m_valid;
    logic                 r_frame_err;

    logic                 w_accept;
    logic                 w_at_last;
    logic                 w_write;
    logic                 w_clear;
    logic                 w_err;

    // Accept is qualified by the registered ready, so nothing lands during HOLD
    // or in the first cycle after reset release.
    assign w_accept  = s_valid && r_s_ready;
    assign w_at_last = (r_cnt == LAST_SLOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL: begin
                if (w_accept && (s_last || w_at_last)) begin
                    w_next = s_last ? HOLD : DRAIN;
                end
            end
            DRAIN: begin
                if (w_accept && s_last) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    w_next = FILL;
                end
            end
            default: w_next = FILL;
        endcase
    end

    always_comb begin
        w_write    = 1'b0;
        w_clear    = 1'b0;
        w_err      = 1'b0;
        w_cnt_next = r_cnt;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    // Short (last before slot N-1) and long (no last at slot N-1) both flag.
                    w_err   = s_last ^ w_at_last;
                    if (s_last || w_at_last) begin
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                w_clear = m_ready;
            end
            default: begin
                w_write = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_s_ready   <= (w_next != HOLD);
            r_m_valid   <= (w_next == HOLD);
            r_frame_err <= w_err;
        end
    end

    // Clearing on HOLD exit is what leaves unwritten slots at zero for short frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec <= '0;
        end else if (w_clear) begin
            r_vec <= '0;
        end else if (w_write) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (CW'(k) == r_cnt) begin
                    r_vec[k*WIDTH +: WIDTH] <= s_data;
                end
            end
        end
    end

    assign s_ready   = r_s_ready;
    assign m_valid   = r_m_valid;
    assign m_vec     = r_vec;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_score_packer.sv
// Scoreboard bench for score_packer: stimulus pushes expected vectors, a negedge
// monitor pops and compares them whenever m_valid rises.
module tb_score_packer;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [W-1:0]     s_data = '0;
    logic             s_last = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [N*W-1:0]   m_vec;
    logic             frame_err;

    score_packer #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_vec     (m_vec),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] vec;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    logic prev_mv = 1'b0;
    logic prev_err = 1'b0;
    logic err_seen = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_mv  = 1'b0;
            prev_err = 1'b0;
            err_seen = 1'b0;
        end else begin
            if (frame_err) begin
                err_seen = 1'b1;
                chk("frame_err_width", 64'(prev_err), 64'd0);
            end
            if (m_valid && !prev_mv) begin
                if (sb.size() == 0) begin
                    chk("unexpected_vec", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("m_vec", m_vec, mon_e.vec);
                    chk("frame_err_seen", 64'(err_seen), 64'(mon_e.err));
                    err_seen = 1'b0;
                end
            end
            prev_mv  = m_valid;
            prev_err = frame_err;
        end
    end

    task automatic beat(input logic [W-1:0] d, input logic last);
        int   g = 0;
        logic rdy;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        forever begin
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            g++;
            if (g > 50) begin
                chk("beat_timeout", 64'd1, 64'd0);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic release_hold();
        int g = 0;
        while (!m_valid && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("hold_wait", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("mvalid_after_take", 64'(m_valid), 64'd0);
        chk("sready_after_take", 64'(s_ready), 64'd1);
        chk("vec_cleared", m_vec, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [W-1:0] normal_d [4];

    initial begin
        normal_d[0] = 16'h0010;
        normal_d[1] = 16'h0200;
        normal_d[2] = 16'h0030;
        normal_d[3] = 16'h0004;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_vec", m_vec, 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        rst_n = 1'b1;
        chk("sready_before_edge", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("sready_after_release", 64'(s_ready), 64'd1);

        // Normal frame with 10-cycle backpressure; ignored traffic during HOLD
        sb.push_back('{64'h0004_0030_0200_0010, 1'b0});
        for (int i = 0; i < 4; i++) beat(normal_d[i], i == 3);
        chk("normal_mvalid", 64'(m_valid), 64'd1);
        chk("normal_sready", 64'(s_ready), 64'd0);
        chk("normal_err", 64'(frame_err), 64'd0);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 16'hDEAD;
            s_last  = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_vec_stable", m_vec, 64'h0004_0030_0200_0010);
            chk("bp_mvalid", 64'(m_valid), 64'd1);
            chk("bp_sready", 64'(s_ready), 64'd0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        release_hold();

        // Short frame: zero padded, one-cycle error pulse with HOLD entry
        sb.push_back('{64'h0000_0000_2222_1111, 1'b1});
        beat(16'h1111, 1'b0);
        beat(16'h2222, 1'b1);
        chk("short_err", 64'(frame_err), 64'd1);
        chk("short_mvalid", 64'(m_valid), 64'd1);
        @(posedge clk);
        #1;
        chk("short_err_drop", 64'(frame_err), 64'd0);
        release_hold();

        // Long frame: truncated after slot 3, extra beats discarded
        sb.push_back('{64'h0004_0003_0002_0001, 1'b1});
        for (int i = 1; i <= 3; i++) beat(16'(i), 1'b0);
        beat(16'd4, 1'b0);
        chk("long_err", 64'(frame_err), 64'd1);
        chk("long_mvalid_drain", 64'(m_valid), 64'd0);
        chk("long_sready_drain", 64'(s_ready), 64'd1);
        beat(16'd5, 1'b0);
        chk("long_no_second_err", 64'(frame_err), 64'd0);
        chk("long_vec_untouched", m_vec, 64'h0004_0003_0002_0001);
        beat(16'd6, 1'b1);
        chk("long_mvalid", 64'(m_valid), 64'd1);
        chk("long_vec", m_vec, 64'h0004_0003_0002_0001);
        release_hold();

        // Gapped input: idle cycle between beats
        sb.push_back('{64'h0004_0030_0200_0010, 1'b0});
        for (int i = 0; i < 4; i++) begin
            beat(normal_d[i], i == 3);
            if (i < 3) begin
                chk("gap_mvalid_early", 64'(m_valid), 64'd0);
                @(posedge clk);
                #1;
            end
        end
        chk("gap_mvalid", 64'(m_valid), 64'd1);
        release_hold();

        // Reset mid-frame, then a full frame starting at slot 0
        beat(16'h5555, 1'b0);
        beat(16'h6666, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", 64'(s_ready), 64'd0);
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_m_vec", m_vec, 64'd0);
        chk("midrst_frame_err", 64'(frame_err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_sready_pre", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_sready_post", 64'(s_ready), 64'd1);
        sb.push_back('{64'h000D_000C_000B_000A, 1'b0});
        beat(16'h000A, 1'b0);
        beat(16'h000B, 1'b0);
        beat(16'h000C, 1'b0);
        beat(16'h000D, 1'b1);
        release_hold();

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/score_packer.md
# score_packer

Serial-to-parallel collector for class scores leaving the final fully-connected stage. It accepts one WIDTH-bit unsigned score per beat on a valid/ready stream and assembles N scores into the packed N*WIDTH vector consumed by the argmax block. It holds each completed vector stable until the downstream side takes it. It also enforces frame length: short frames are zero-padded, long frames are truncated, and both are flagged.

## Interface
- N, 4: scores per frame (classes); N >= 2
- WIDTH, 16: bits per unsigned score
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  upstream beat valid
- s_ready  out  1  upstream beat accepted when s_valid && s_ready (registered)
- s_data  in  WIDTH  score value
- s_last  in  1  marks final beat of a frame
- m_valid  out  1  packed vector available (registered)
- m_ready  in  1  downstream consumes vector when m_valid && m_ready
- m_vec  out  N*WIDTH  packed scores; score k at bits [k*WIDTH +: WIDTH]; first accepted beat is k=0
- frame_err  out  1  one-cycle pulse on short or long frame (registered)

## Operation
- State machine: FILL, DRAIN, HOLD. Reset state FILL. Slot counter cnt is $clog2(N) bits, reset 0.
- FILL: s_ready=1, m_valid=0. On each accepted beat, write s_data into slot cnt.
  - Beat with cnt==N-1 and s_last=1: normal end. cnt<=0, go HOLD.
  - Beat with cnt<N-1 and s_last=1: short frame. Unwritten slots keep 0 because the vector is cleared on HOLD exit. Pulse frame_err, cnt<=0, go HOLD.
  - Beat with cnt==N-1 and s_last=0: long frame. Pulse frame_err, cnt<=0, go DRAIN.
  - Otherwise cnt<=cnt+1.
- DRAIN: s_ready=1, m_valid=0. Accepted beats are discarded and m_vec is untouched. The beat with s_last=1 moves the block to HOLD. There is no second frame_err pulse.
- HOLD: s_ready=0, m_valid=1, m_vec frozen. When m_ready=1, clear m_vec to 0 and go FILL.
- Zero padding is safe for argmax: unsigned 0 never beats a real score, and ties resolve to the lower index.
- No arithmetic on data. Scores pass through bit-exact.

## Timing
- Reset values: s_ready=0, m_valid=0, m_vec=0, frame_err=0, state FILL, cnt=0. s_ready rises on the first clk edge after rst_n deasserts.
- s_ready and m_valid are registered, derived from the next state: s_ready = (next!=HOLD), m_valid = (next==HOLD).
- Latency: m_valid rises on the edge that accepts the final beat. A normal frame takes N accept cycles plus at least 1 HOLD cycle, so peak throughput is one frame per N+1 cycles.
- frame_err is high for exactly the cycle after the offending beat is accepted, coincident with entry to HOLD or DRAIN.
- m_ready is ignored outside HOLD. s_valid, s_data and s_last are ignored when s_ready=0.
- When HOLD exits with m_ready=1, the following cycle is FILL with s_ready=1. No beat is accepted in the HOLD-exit cycle.
- An N=1 frame is illegal (N >= 2). With s_last=1 on the first beat, slot 0 is filled, the rest are 0, and frame_err pulses.
- rst_n asserted mid-frame or mid-HOLD: all state and outputs return to reset values immediately (asynchronous). The partial frame is lost.

## Structure
- The shared package cnn_pkg holds the state enum (FILL, DRAIN, HOLD) and the default N and WIDTH constants, which are shared with argmax.
- There is no sub-module. The block is one FSM, a counter and an N-slot register file.
- The top level connects m_vec directly to argmax in_vec and qualifies argmax max_index with m_valid.

## Test plan
- Normal frame, N=4, WIDTH=16: beats 0x0010, 0x0200, 0x0030, 0x0004 with s_last on beat 4 -> m_valid the next cycle, m_vec=0x0004_0030_0200_0010, frame_err=0, s_ready=0 until m_ready.
- Backpressure: hold m_ready=0 for 10 cycles, then 1 -> m_vec stable throughout, m_valid drops after one handshake, s_ready=1 the next cycle, m_vec reads 0.
- Short frame: beats 0x1111, 0x2222 with s_last on beat 2 -> m_vec=0x0000_0000_2222_1111, frame_err pulses for 1 cycle.
- Long frame: 6 beats 1..6 with s_last on beat 6 -> frame_err pulse after beat 4, beats 5 and 6 are discarded, m_vec=0x0004_0003_0002_0001.
- Gapped input: s_valid toggles every other cycle for 4 beats -> same packing as the continuous case, and m_valid appears after the 4th accept.
- Reset mid-frame: assert rst_n=0 after 2 beats, then release -> all outputs 0, s_ready=1 one edge after release, and the next full frame packs from slot 0.
